// File: rtl/xs3_pkg.sv
// Shared Excess-3 constants, FSM state encoding and digit helpers for the
// sequential Excess-3 multiplier.
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_ZERO   = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  // A code is a legal Excess-3 digit only inside 3..12.
  function automatic logic xs3_valid(input logic [3:0] code);
    return (code >= 4'd3) && (code <= 4'd12);
  endfunction

  function automatic logic [3:0] xs3_dec(input logic [3:0] code);
    return code - XS3_OFFSET;
  endfunction

  function automatic logic [3:0] xs3_enc(input logic [3:0] value);
    return value + XS3_OFFSET;
  endfunction

endpackage

// File: rtl/xs3_digit_mac.sv
// Combinational single-digit multiply-accumulate: one Excess-3 product digit
// plus the decimal carry into the next digit position.
module xs3_digit_mac
  import xs3_pkg::*;
(
  input  logic [3:0] a_digit,
  input  logic [3:0] b_digit,
  input  logic [3:0] carry_in,
  output logic [3:0] sum_digit,
  output logic [3:0] carry_out
);

  // 9*9+8 = 89 is the largest legal sum, so 7 bits never overflow.
  logic [6:0] s;

  always_comb begin
    s         = 7'(xs3_dec(a_digit)) * 7'(xs3_dec(b_digit)) + 7'(carry_in);
    sum_digit = xs3_enc(4'(s % 7'd10));
    carry_out = 4'(s / 7'd10);
  end

endmodule

// File: rtl/xs3_mul_seq.sv
// N-digit Excess-3 multiplicand times one Excess-3 digit, one digit per clock,
// least significant first, with a start/busy/done handshake.
module xs3_mul_seq
  import xs3_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*N-1:0]     a_in,
  input  logic [3:0]         b_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [4*(N+1)-1:0] product
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                 state_q, state_d;
  logic [N-1:0][3:0]      a_q, a_d;
  logic [3:0]             b_q, b_d;
  logic [3:0]             carry_q, carry_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N-1:0][3:0]      shadow_q, shadow_d;
  logic [N:0][3:0]        prod_q, prod_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   operand_bad;
  logic [3:0]             mac_sum;
  logic [3:0]             mac_carry;

  xs3_digit_mac u_mac (
    .a_digit  (a_q[idx_q]),
    .b_digit  (b_q),
    .carry_in (carry_q),
    .sum_digit(mac_sum),
    .carry_out(mac_carry)
  );

  // Operands are checked as they arrive so a bad code skips CALC entirely.
  always_comb begin
    operand_bad = !xs3_valid(b_in);
    for (int i = 0; i < N; i++) begin
      if (!xs3_valid(a_in[4*i +: 4])) operand_bad = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    prod_d   = prod_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          if (operand_bad) begin
            prod_d  = {(N+1){XS3_ZERO}};
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        shadow_d[idx_q] = mac_sum;
        carry_d         = mac_carry;
        idx_d           = idx_q + 1'b1;
        // Product is published only with the last digit, never partially.
        if (idx_q == LAST_IDX) begin
          prod_d  = {xs3_enc(mac_carry), shadow_d};
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      // NOTE: the operand and shadow registers are reset too; it is cheap here
      // and keeps the idle datapath deterministic for equivalence checks.
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      prod_q   <= {(N+1){XS3_ZERO}};
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      prod_q   <= prod_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign product = prod_q;

endmodule

// File: tb/tb_xs3_mul_seq.sv
// Scoreboard bench for xs3_mul_seq (N=4): directed vectors push expected
// results, an independent monitor pops and compares on every done pulse.
module tb_xs3_mul_seq;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [3:0]  b_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [19:0] product;

  typedef struct packed {
    logic [19:0] prod;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;

  xs3_mul_seq #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compares every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 20'd1, 20'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("product", product, e.prod);
        check("err", 20'(err), 20'(e.err));
      end
    end
  end

  // Issue one operation and check the busy/done timing around it.
  task automatic run_op(input logic [15:0] a, input logic [3:0] b,
                        input logic [19:0] exp_p, input logic exp_e, input int exp_busy);
    int  busy_cyc;
    bit  seen;
    busy_cyc = 0;
    seen     = 0;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb_q.push_back('{exp_p, exp_e});
    @(negedge clk);
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (busy) busy_cyc++;
      if (done) seen = 1;
      else @(negedge clk);
    end
    check("done_seen", 20'(seen), 20'd1);
    check("busy_cycles", 20'(busy_cyc), 20'(exp_busy));
    @(negedge clk);
    check("idle_busy", 20'(busy), 20'd0);
    check("idle_done", 20'(done), 20'd0);
  endtask

  initial begin
    int  base;
    bit  seen;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 20'(busy), 20'd0);
    check("rst_done", 20'(done), 20'd0);
    check("rst_err", 20'(err), 20'd0);
    check("rst_product", product, 20'h33333);
    rst = 1'b0;

    // Valid operands: N+1 busy cycles, done on the last one.
    run_op(16'h4567, 4'h8, 20'h394A3, 1'b0, N + 1);  // 1234 x 5 = 06170
    run_op(16'hCCCC, 4'hC, 20'hBCCC4, 1'b0, N + 1);  // 9999 x 9 = 89991
    run_op(16'h3333, 4'hA, 20'h33333, 1'b0, N + 1);  // 0000 x 7
    run_op(16'h4567, 4'h3, 20'h33333, 1'b0, N + 1);  // 1234 x 0
    run_op(16'h89AB, 4'h6, 20'h4A367, 1'b0, N + 1);  // 5678 x 3 = 17034
    run_op(16'hC3C3, 4'h4, 20'h3C3C3, 1'b0, N + 1);  // 9090 x 1, codes 12 and 3

    // Invalid codes: done with err one cycle after start.
    run_op(16'h45F7, 4'h8, 20'h33333, 1'b1, 1);
    run_op(16'h4567, 4'h0, 20'h33333, 1'b1, 1);
    run_op(16'h4567, 4'hD, 20'h33333, 1'b1, 1);
    run_op(16'h2567, 4'h8, 20'h33333, 1'b1, 1);
    run_op(16'h4567, 4'h8, 20'h394A3, 1'b0, N + 1);  // err clears on next start

    // start while busy is ignored: one done, first operands' result.
    base = done_cnt;
    @(negedge clk);
    a_in = 16'h4567; b_in = 4'h8; start = 1'b1;
    sb_q.push_back('{20'h394A3, 1'b0});
    @(negedge clk);
    a_in = 16'hCCCC; b_in = 4'hC;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (N + 4) @(negedge clk);
    check("busy_start_one_done", 20'(done_cnt - base), 20'd1);

    // start held during FIN is not accepted on the FIN->IDLE edge.
    base = done_cnt;
    seen = 0;
    @(negedge clk);
    a_in = 16'h89AB; b_in = 4'h6; start = 1'b1;
    sb_q.push_back('{20'h4A367, 1'b0});
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    check("fin_done_seen", 20'(seen), 20'd1);
    a_in = 16'hCCCC; b_in = 4'hC; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fin_start_ignored", 20'(busy), 20'd0);
    repeat (3) @(negedge clk);
    check("fin_start_no_done", 20'(done_cnt - base), 20'd1);

    // Reset in the second CALC cycle aborts without a done pulse.
    base = done_cnt;
    @(negedge clk);
    a_in = 16'hCCCC; b_in = 4'hC; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 20'(busy), 20'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 20'(busy), 20'd0);
    check("abort_done", 20'(done), 20'd0);
    check("abort_product", product, 20'h33333);
    check("abort_err", 20'(err), 20'd0);
    rst = 1'b0;
    repeat (N + 3) @(negedge clk);
    check("abort_no_done", 20'(done_cnt - base), 20'd0);
    run_op(16'h4567, 4'h8, 20'h394A3, 1'b0, N + 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 20'(sb_q.size()), 20'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
